// File: rtl/aap_pipeline_pkg.sv
// Shared AAP pipeline definitions: datapath widths, the instruction-length
// bit, and the bundle handed from fetch to decode.
package aap_pipeline_pkg;

  localparam int PC_WIDTH    = 20;
  localparam int IWORD_WIDTH = 16;
  localparam int INSTR_WIDTH = 32;
  localparam int IS32_BIT    = 15;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] data;
    logic                   is32;
    logic [PC_WIDTH-1:0]    pc;
  } instr_bundle_t;

  // A word with the length bit set opens a two-word instruction.
  function automatic logic word_is32(input logic [IWORD_WIDTH-1:0] word);
    return word[IS32_BIT];
  endfunction

endpackage

// File: rtl/fetch_queue_buffer.sv
// Circular word store for the fetch queue: DEPTH x 16-bit entries with a
// single-word push, one- or two-word pop, flush, occupancy count and read
// ports for the head word and the word behind it.
module fetch_queue_buffer
  import aap_pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [IWORD_WIDTH-1:0]   push_data,
  input  logic                     pop1,
  input  logic                     pop2,
  output logic [$clog2(DEPTH):0]   count,
  output logic [IWORD_WIDTH-1:0]   head_word,
  output logic [IWORD_WIDTH-1:0]   next_word
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IWORD_WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0]       head_ptr;
  logic [PTR_W-1:0]       tail_ptr;
  logic [CNT_W-1:0]       pop_amt;

  // Number of words leaving the head this cycle.
  always_comb begin
    pop_amt = '0;
    if (pop2)
      pop_amt = CNT_W'(2);
    else if (pop1)
      pop_amt = CNT_W'(1);
  end

  assign head_word = storage[head_ptr];
  assign next_word = storage[head_ptr + PTR_W'(1)];

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push)
        tail_ptr <= tail_ptr + PTR_W'(1);
      head_ptr <= head_ptr + PTR_W'(pop_amt);
      count    <= count + CNT_W'(push) - pop_amt;
    end
  end

  // Word storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (push && !flush)
      storage[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential 16-bit reads, buffers the
// returned words, assembles 16/32-bit AAP instructions for the decoder and
// flushes/refetches on a branch redirect.
// Optional build macro FETCH_QUEUE_PERF_EN adds saturating stall_count and
// flush_count outputs.
module fetch_queue
  import aap_pipeline_pkg::*;
#(
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 20'h00000
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    imem_rd_addr,
  output logic                   imem_rd_en,
  input  logic [IWORD_WIDTH-1:0] imem_rd_data,
  input  logic                   redirect_en,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic                   instr_is32,
  output logic [PC_WIDTH-1:0]    instr_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [15:0]            stall_count,
  output logic [15:0]            flush_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       occupancy;
  logic [IWORD_WIDTH-1:0] head_word;
  logic [IWORD_WIDTH-1:0] next_word;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    head_pc;
  logic                   inflight;
  logic                   head_is32;
  logic                   req;
  logic                   valid;
  logic                   fire;
  logic                   push;
  instr_bundle_t          bundle;

  assign head_is32 = word_is32(head_word);
  // Buffered words plus the one still on its way back from memory.
  assign occupancy = count + CNT_W'(inflight);

  // Request, length decode and handshake qualification.
  always_comb begin
    req   = !reset && !redirect_en && (occupancy < CNT_W'(DEPTH));
    valid = 1'b0;
    if (!redirect_en)
      valid = head_is32 ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));
    fire  = valid && instr_ready;
    // A word returning during a redirect belongs to the abandoned path.
    push  = inflight && !redirect_en;
  end

  // Instruction bundle driven from the head entries, zero when not valid.
  always_comb begin
    bundle = '0;
    if (valid) begin
      bundle.data = {(head_is32 ? next_word : {IWORD_WIDTH{1'b0}}), head_word};
      bundle.is32 = head_is32;
      bundle.pc   = head_pc;
    end
  end

  assign imem_rd_en   = req;
  assign imem_rd_addr = reset ? '0 : fetch_pc;
  assign instr_valid  = valid;
  assign instr_data   = bundle.data;
  assign instr_is32   = bundle.is32;
  assign instr_pc     = bundle.pc;

  fetch_queue_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_en),
    .push      (push),
    .push_data (imem_rd_data),
    .pop1      (fire && !head_is32),
    .pop2      (fire && head_is32),
    .count     (count),
    .head_word (head_word),
    .next_word (next_word)
  );

  // Fetch address, head address and in-flight tracking; redirect wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (redirect_en) begin
        fetch_pc <= redirect_pc;
        head_pc  <= redirect_pc;
      end else begin
        if (req)
          fetch_pc <= fetch_pc + PC_WIDTH'(1);
        if (fire)
          head_pc <= head_pc + (head_is32 ? PC_WIDTH'(2) : PC_WIDTH'(1));
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // Decoder backpressure and redirect event counters, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (valid && !instr_ready)
        stall_count <= sat_inc(stall_count);
      if (redirect_en)
        flush_count <= sat_inc(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a one-cycle-latency memory model.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] imem_rd_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rd_data;
  logic        redirect_en = 1'b0;
  logic [19:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic        instr_is32;
  logic [19:0] instr_pc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  logic [15:0] mem [0:255];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(20'h00000)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_rd_addr (imem_rd_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_rd_data (imem_rd_data),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_is32   (instr_is32),
    .instr_pc     (instr_pc)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .stall_count  (stall_count),
    .flush_count  (flush_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory answers one cycle after a request; garbage otherwise.
  always @(posedge clock)
    imem_rd_data <= imem_rd_en ? mem[imem_rd_addr[7:0]] : 16'hEEEE;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_instr(input string tag, input logic [31:0] data,
                             input logic is32, input logic [19:0] pc);
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".data"},  instr_data,       data);
    check({tag, ".is32"},  32'(instr_is32),  32'(is32));
    check({tag, ".pc"},    32'(instr_pc),    32'(pc));
  endtask

  task automatic fill(input logic [15:0] base);
    for (int i = 0; i < 256; i++)
      mem[i] = base + 16'(i);
  endtask

  task automatic hold_reset();
    reset       = 1'b1;
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_reset(input logic ready);
    reset       = 1'b0;
    instr_ready = ready;
    #1;
  endtask

  initial begin
    fill(16'h1000);
    #1;
    // ---- reset state
    hold_reset();
    check("rst.rd_en",   32'(imem_rd_en),   32'd0);
    check("rst.rd_addr", 32'(imem_rd_addr), 32'd0);
    check("rst.valid",   32'(instr_valid),  32'd0);
    check("rst.data",    instr_data,        32'd0);
    check("rst.is32",    32'(instr_is32),   32'd0);
    check("rst.pc",      32'(instr_pc),     32'd0);

    // ---- streaming 16-bit instructions
    fill(16'h1000);
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003;
    release_reset(1'b1);
    check("s.c0.rd_en", 32'(imem_rd_en),   32'd1);
    check("s.c0.addr",  32'(imem_rd_addr), 32'd0);
    check("s.c0.valid", 32'(instr_valid),  32'd0);
    tick();
    check("s.c1.valid", 32'(instr_valid),  32'd0);
    check("s.c1.addr",  32'(imem_rd_addr), 32'd1);
    tick();
    check_instr("s.i0", 32'h0000_1001, 1'b0, 20'h0);
    tick();
    check_instr("s.i1", 32'h0000_1002, 1'b0, 20'h1);
    tick();
    check_instr("s.i2", 32'h0000_1003, 1'b0, 20'h2);

    // ---- 32-bit instruction split across two words
    hold_reset();
    mem[0] = 16'h8123; mem[1] = 16'h4567; mem[2] = 16'h1111;
    release_reset(1'b1);
    tick();
    tick();
    check("w.half.valid", 32'(instr_valid), 32'd0);
    tick();
    check_instr("w.i0", 32'h4567_8123, 1'b1, 20'h0);
    tick();
    check_instr("w.i1", 32'h0000_1111, 1'b0, 20'h2);

    // ---- backpressure for 10 cycles
    hold_reset();
    fill(16'h2000);
    release_reset(1'b0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c >= 2) begin
        check("bp.data", instr_data, 32'h0000_2000);
        check("bp.pc",   32'(instr_pc), 32'd0);
      end
      if (c >= 4)
        check("bp.rd_en", 32'(imem_rd_en), 32'd0);
    end
    instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_instr("bp.drain", 32'h0000_2000 + 32'(k), 1'b0, 20'(k));
      tick();
    end

    // ---- redirect with a read in flight
    hold_reset();
    fill(16'h3000);
    mem[8'h40] = 16'h5040; mem[8'h41] = 16'h5041; mem[8'h10] = 16'h6010;
    release_reset(1'b0);
    tick();
    redirect_en = 1'b1;
    redirect_pc = 20'h00040;
    #1;
    check("rd.c1.rd_en", 32'(imem_rd_en),  32'd0);
    check("rd.c1.valid", 32'(instr_valid), 32'd0);
    tick();
    redirect_en = 1'b0;
    #1;
    check("rd.c2.addr",  32'(imem_rd_addr), 32'h40);
    check("rd.c2.valid", 32'(instr_valid),  32'd0);
    tick();
    check("rd.c3.addr",  32'(imem_rd_addr), 32'h41);
    check("rd.c3.valid", 32'(instr_valid),  32'd0);
    tick();
    check_instr("rd.i0", 32'h0000_5040, 1'b0, 20'h40);
    instr_ready = 1'b1;
    tick();
    check_instr("rd.i1", 32'h0000_5041, 1'b0, 20'h41);
    redirect_en = 1'b1;
    redirect_pc = 20'h00010;
    #1;
    check("rd.busy.valid", 32'(instr_valid), 32'd0);
    check("rd.busy.data",  instr_data,       32'd0);
    tick();
    redirect_en = 1'b0;
    #1;
    check("rd.c6.addr", 32'(imem_rd_addr), 32'h10);
    tick();
    tick();
    check_instr("rd.i2", 32'h0000_6010, 1'b0, 20'h10);

    // ---- reset mid-operation with a read in flight
    hold_reset();
    fill(16'h7000);
    release_reset(1'b0);
    tick(); tick(); tick(); tick();
    check("mr.full.rd_en", 32'(imem_rd_en), 32'd0);
    reset = 1'b1;
    #1;
    check("mr.rd_en", 32'(imem_rd_en),   32'd0);
    check("mr.addr",  32'(imem_rd_addr), 32'd0);
    check("mr.valid", 32'(instr_valid),  32'd0);
    check("mr.data",  instr_data,        32'd0);
    check("mr.pc",    32'(instr_pc),     32'd0);
    mem[0] = 16'h7777;
    #2;
    reset = 1'b0;
    #1;
    check("mr.r0.rd_en", 32'(imem_rd_en),   32'd1);
    check("mr.r0.addr",  32'(imem_rd_addr), 32'd0);
    tick();
    check("mr.r1.valid", 32'(instr_valid), 32'd0);
    tick();
    check_instr("mr.i0", 32'h0000_7777, 1'b0, 20'h0);

`ifdef FETCH_QUEUE_PERF_EN
    // ---- performance counters: 5 stalls, 2 redirects
    hold_reset();
    fill(16'h0100);
    release_reset(1'b0);
    check("pf.rst.stall", 32'(stall_count), 32'd0);
    for (int c = 0; c < 7; c++)
      tick();
    redirect_en = 1'b1;
    redirect_pc = 20'h00020;
    tick();
    tick();
    redirect_en = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("pf.stall", 32'(stall_count), 32'd5);
    check("pf.flush", 32'(flush_count), 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
